// File: rtl/vga_text_console.sv
// Character-stream front end for the colour text frame buffer.
// Accepts one byte at a time with a colour attribute, keeps a cursor,
// writes symbol halfwords into the frame buffer, interprets CR/LF/BS/FF
// and scrolls the screen up one row when the cursor runs off the bottom.
module vga_text_console #(
    parameter int          SCREEN_COLS = 80,
    parameter int          SCREEN_ROWS = 30,
    parameter logic [7:0]  BLANK_CHAR  = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ch_valid,
    input  logic [7:0]  ch_data,
    input  logic [7:0]  ch_attr,
    output logic        ch_ready,
    output logic        fb_en,
    output logic [3:0]  fb_we,
    output logic [10:0] fb_addr,
    output logic [31:0] fb_wdata,
    input  logic [31:0] fb_rdata,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic        busy
);

    localparam int WORDS_PER_ROW = SCREEN_COLS / 2;
    localparam int SCROLL_WORDS  = WORDS_PER_ROW * (SCREEN_ROWS - 1);
    localparam int TOTAL_WORDS   = WORDS_PER_ROW * SCREEN_ROWS;

    localparam logic [4:0]  LAST_ROW   = 5'(SCREEN_ROWS - 1);
    localparam logic [6:0]  LAST_COL   = 7'(SCREEN_COLS - 1);
    localparam logic [10:0] W_WORDS    = 11'(WORDS_PER_ROW);
    localparam logic [10:0] SCROLL_END = 11'(SCROLL_WORDS - 1);
    localparam logic [10:0] SCROLL_N   = 11'(SCROLL_WORDS);
    localparam logic [10:0] CLEAR_END  = 11'(TOTAL_WORDS - 1);

    typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, CLR} state_t;

    state_t       state_q, state_d;
    logic [4:0]   row_q, row_d;
    logic [6:0]   col_q, col_d;
    logic [10:0]  cnt_q, cnt_d;
    logic [7:0]   code_q, code_d;
    logic [7:0]   attr_q, attr_d;
    logic         fb_en_q, fb_en_d;
    logic [3:0]   fb_we_q, fb_we_d;
    logic [10:0]  fb_addr_q, fb_addr_d;
    logic [31:0]  fb_wdata_q, fb_wdata_d;
    logic [10:0]  cursor_addr;

    // Word holding the cursor cell.
    assign cursor_addr = 11'(row_q) * W_WORDS + {5'd0, col_q[6:1]};

    // Next-state, cursor update, and the frame-buffer access for the
    // upcoming state so that the registered port lines up with that state.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        attr_d     = attr_q;
        fb_en_d    = 1'b0;
        fb_we_d    = 4'b0000;
        fb_addr_d  = fb_addr_q;
        fb_wdata_d = fb_wdata_q;

        case (state_q)
            IDLE: begin
                if (ch_valid) begin
                    code_d = ch_data;
                    attr_d = ch_attr;
                    case (ch_data)
                        8'h0D: col_d = 7'd0;
                        8'h08: begin
                            if (col_q != 7'd0) col_d = col_q - 7'd1;
                        end
                        8'h0A: begin
                            col_d = 7'd0;
                            if (row_q < LAST_ROW) begin
                                row_d = row_q + 5'd1;
                            end else begin
                                state_d = SCR_RD;
                                cnt_d   = 11'd0;
                            end
                        end
                        8'h0C: begin
                            row_d   = 5'd0;
                            col_d   = 7'd0;
                            state_d = CLR;
                            cnt_d   = 11'd0;
                        end
                        default: state_d = PUT;
                    endcase
                end
            end
            PUT: begin
                state_d = IDLE;
                if (col_q < LAST_COL) begin
                    col_d = col_q + 7'd1;
                end else begin
                    col_d = 7'd0;
                    if (row_q < LAST_ROW) begin
                        row_d = row_q + 5'd1;
                    end else begin
                        state_d = SCR_RD;
                        cnt_d   = 11'd0;
                    end
                end
            end
            SCR_RD: state_d = SCR_WR;
            SCR_WR: begin
                if (cnt_q < SCROLL_END) begin
                    cnt_d   = cnt_q + 11'd1;
                    state_d = SCR_RD;
                end else begin
                    cnt_d   = SCROLL_N;
                    state_d = CLR;
                end
            end
            CLR: begin
                if (cnt_q == CLEAR_END) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            PUT: begin
                fb_en_d    = 1'b1;
                fb_addr_d  = cursor_addr;
                fb_we_d    = col_q[0] ? 4'b0011 : 4'b1100;
                fb_wdata_d = {attr_d, code_d, attr_d, code_d};
            end
            SCR_RD: begin
                fb_en_d   = 1'b1;
                fb_addr_d = cnt_d + W_WORDS;
            end
            SCR_WR: begin
                fb_en_d   = 1'b1;
                fb_we_d   = 4'hF;
                fb_addr_d = cnt_d;
            end
            CLR: begin
                fb_en_d    = 1'b1;
                fb_we_d    = 4'hF;
                fb_addr_d  = cnt_d;
                fb_wdata_d = {attr_d, BLANK_CHAR, attr_d, BLANK_CHAR};
            end
            default: ;
        endcase
    end

    // State, cursor and frame-buffer port registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= 5'd0;
            col_q      <= 7'd0;
            cnt_q      <= 11'd0;
            code_q     <= 8'd0;
            attr_q     <= 8'd0;
            fb_en_q    <= 1'b0;
            fb_we_q    <= 4'b0000;
            fb_addr_q  <= 11'd0;
            fb_wdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            attr_q     <= attr_d;
            fb_en_q    <= fb_en_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_wdata_q <= fb_wdata_d;
        end
    end

    // The scroll copy arrives from the synchronous-read port during SCR_WR,
    // so that write forwards the read data straight through; the mux select
    // is the registered state, keeping the copy at two cycles per word.
    assign fb_wdata   = (state_q == SCR_WR) ? fb_rdata : fb_wdata_q;
    assign fb_en      = fb_en_q;
    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign ch_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign cursor_row = row_q;
    assign cursor_col = col_q;

endmodule

// File: tb/tb_vga_text_console.sv
// Self-checking bench for vga_text_console with a synchronous frame-buffer model.
module tb_vga_text_console;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ch_valid = 1'b0;
    logic [7:0]  ch_data = 8'h00;
    logic [7:0]  ch_attr = 8'h00;
    logic        ch_ready;
    logic        fb_en;
    logic [3:0]  fb_we;
    logic [10:0] fb_addr;
    logic [31:0] fb_wdata;
    logic [31:0] fb_rdata = 32'h0;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        busy;

    vga_text_console dut (
        .clk(clk), .reset(reset),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_attr(ch_attr), .ch_ready(ch_ready),
        .fb_en(fb_en), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .fb_rdata(fb_rdata), .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
    );

    always #5 clk = ~clk;

    // Frame-buffer model: synchronous read, byte-enabled write, write log.
    logic [31:0] mem [0:1199];
    logic [10:0] log_addr [0:8191];
    logic [3:0]  log_we   [0:8191];
    logic [31:0] log_data [0:8191];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic        preload = 1'b0;

    always @(posedge clk) begin
        if (preload) begin
            for (int r = 0; r < 30; r++)
                for (int w = 0; w < 40; w++)
                    mem[r*40+w] <= {8'h2E, 8'h40 + 8'(r), 8'h2E, 8'h40 + 8'(r)};
        end else if (fb_en) begin
            if (fb_we == 4'b0000) begin
                if (fb_addr < 11'd1200) fb_rdata <= mem[fb_addr];
                rd_cnt <= rd_cnt + 1;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (fb_we[b] && fb_addr < 11'd1200) mem[fb_addr][b*8 +: 8] <= fb_wdata[b*8 +: 8];
                log_addr[wr_cnt % 8192] <= fb_addr;
                log_we[wr_cnt % 8192]   <= fb_we;
                log_data[wr_cnt % 8192] <= fb_wdata;
                wr_cnt <= wr_cnt + 1;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Send one byte at a negedge when ready; return cycles the console stays busy.
    task automatic send(input logic [7:0] d, input logic [7:0] a, output int busy_cycles);
        int t;
        t = 0;
        while (!ch_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!ch_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: ch_ready still %0b, expected 1", ch_ready);
        end
        ch_valid = 1'b1;
        ch_data  = d;
        ch_attr  = a;
        @(negedge clk);
        ch_valid = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < 5000) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic send_n(input logic [7:0] d, input logic [7:0] a, input int n);
        int bc;
        for (int i = 0; i < n; i++) send(d, a, bc);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [7:0]  attr;
        logic [4:0]  exp_row;
        logic [6:0]  exp_col;
        int          exp_nwr;
        int          exp_busy;
        logic [10:0] exp_addr;
        logic [3:0]  exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [0:7];

    initial begin
        int bc, w0, r0, errs;
        string nm;

        vecs[0] = '{8'h41, 8'h1F, 5'd0, 7'd1, 1, 1, 11'd0,  4'b1100, 32'h1F41_1F41};
        vecs[1] = '{8'h42, 8'h1F, 5'd0, 7'd2, 1, 1, 11'd0,  4'b0011, 32'h1F42_1F42};
        vecs[2] = '{8'h0D, 8'h00, 5'd0, 7'd0, 0, 0, 11'd0,  4'b0000, 32'h0};
        vecs[3] = '{8'h08, 8'h00, 5'd0, 7'd0, 0, 0, 11'd0,  4'b0000, 32'h0};
        vecs[4] = '{8'h0A, 8'h00, 5'd1, 7'd0, 0, 0, 11'd0,  4'b0000, 32'h0};
        vecs[5] = '{8'h0A, 8'h00, 5'd2, 7'd0, 0, 0, 11'd0,  4'b0000, 32'h0};
        vecs[6] = '{8'h78, 8'h5A, 5'd2, 7'd1, 1, 1, 11'd80, 4'b1100, 32'h5A78_5A78};
        vecs[7] = '{8'h08, 8'h00, 5'd2, 7'd0, 0, 0, 11'd0,  4'b0000, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", ch_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_fb_en", fb_en, 0);
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_wdata", fb_wdata, 0);
        check("rst_cursor", {cursor_row, cursor_col}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven single-byte transactions
        for (int i = 0; i < 8; i++) begin
            w0 = wr_cnt;
            send(vecs[i].data, vecs[i].attr, bc);
            $display("vec %0d: byte %02h attr %02h -> cursor (%0d,%0d) writes %0d busy %0d",
                     i, vecs[i].data, vecs[i].attr, cursor_row, cursor_col, wr_cnt - w0, bc);
            nm = $sformatf("vec%0d", i);
            check({nm, "_row"}, cursor_row, vecs[i].exp_row);
            check({nm, "_col"}, cursor_col, vecs[i].exp_col);
            check({nm, "_nwr"}, wr_cnt - w0, vecs[i].exp_nwr);
            check({nm, "_busy"}, bc, vecs[i].exp_busy);
            if (vecs[i].exp_nwr == 1) begin
                check({nm, "_addr"}, log_addr[w0 % 8192], vecs[i].exp_addr);
                check({nm, "_we"}, log_we[w0 % 8192], vecs[i].exp_we);
                check({nm, "_wdata"}, log_data[w0 % 8192], vecs[i].exp_wdata);
            end
        end

        // Last column wraps to next row: 'C' at (2,79)
        send_n(8'h61, 8'h07, 79);
        check("to_2_79", {cursor_row, cursor_col}, {5'd2, 7'd79});
        w0 = wr_cnt;
        send(8'h43, 8'h1F, bc);
        $display("C at (2,79): addr %0d we %b wdata %08h cursor (%0d,%0d)",
                 log_addr[w0 % 8192], log_we[w0 % 8192], log_data[w0 % 8192], cursor_row, cursor_col);
        check("C_addr", log_addr[w0 % 8192], 119);
        check("C_we", log_we[w0 % 8192], 4'b0011);
        check("C_wdata", log_data[w0 % 8192], 32'h1F43_1F43);
        check("C_cursor", {cursor_row, cursor_col}, {5'd3, 7'd0});

        // CR at (4,37)
        send(8'h0A, 8'h00, bc);
        send_n(8'h62, 8'h07, 37);
        check("to_4_37", {cursor_row, cursor_col}, {5'd4, 7'd37});
        send(8'h0D, 8'h00, bc);
        $display("CR at (4,37): cursor (%0d,%0d)", cursor_row, cursor_col);
        check("CR_cursor", {cursor_row, cursor_col}, {5'd4, 7'd0});

        // Form feed: full clear
        w0 = wr_cnt;
        send(8'h0C, 8'h70, bc);
        errs = 0;
        for (int i = 0; i < 1200; i++) begin
            if (log_addr[(w0 + i) % 8192] != 11'(i) || log_we[(w0 + i) % 8192] != 4'hF ||
                log_data[(w0 + i) % 8192] != 32'h7020_7020) errs++;
        end
        $display("FF: busy %0d writes %0d bad entries %0d cursor (%0d,%0d)",
                 bc, wr_cnt - w0, errs, cursor_row, cursor_col);
        check("FF_busy", bc, 1200);
        check("FF_nwr", wr_cnt - w0, 1200);
        check("FF_seq_errs", errs, 0);
        check("FF_cursor", {cursor_row, cursor_col}, 0);
        check("FF_mem_last", mem[1199], 32'h7020_7020);

        // Scroll on LF at the last row
        @(negedge clk); preload = 1'b1;
        @(negedge clk); preload = 1'b0;
        send_n(8'h0A, 8'h00, 29);
        send_n(8'h5D, 8'h2E, 5);
        check("to_29_5", {cursor_row, cursor_col}, {5'd29, 7'd5});
        w0 = wr_cnt;
        r0 = rd_cnt;
        send(8'h0A, 8'h35, bc);
        errs = 0;
        for (int r = 0; r < 29; r++)
            for (int w = 0; w < 40; w++)
                if (mem[r*40+w] != {8'h2E, 8'h41 + 8'(r), 8'h2E, 8'h41 + 8'(r)}) errs++;
        for (int w = 0; w < 40; w++)
            if (mem[1160+w] != 32'h3520_3520) errs++;
        $display("LF scroll: busy %0d reads %0d writes %0d bad words %0d cursor (%0d,%0d)",
                 bc, rd_cnt - r0, wr_cnt - w0, errs, cursor_row, cursor_col);
        check("LF_busy", bc, 2360);
        check("LF_reads", rd_cnt - r0, 1160);
        check("LF_writes", wr_cnt - w0, 1200);
        check("LF_mem_errs", errs, 0);
        check("LF_cursor", {cursor_row, cursor_col}, {5'd29, 7'd0});

        // Printable at (29,79): put then scroll
        send_n(8'h71, 8'h07, 79);
        check("to_29_79", {cursor_row, cursor_col}, {5'd29, 7'd79});
        w0 = wr_cnt;
        send(8'h5A, 8'h4A, bc);
        $display("Z at (29,79): first write addr %0d we %b, busy %0d, writes %0d, word1159 %08h",
                 log_addr[w0 % 8192], log_we[w0 % 8192], bc, wr_cnt - w0, mem[1159]);
        check("Z_addr", log_addr[w0 % 8192], 1199);
        check("Z_we", log_we[w0 % 8192], 4'b0011);
        check("Z_wdata", log_data[w0 % 8192], 32'h4A5A_4A5A);
        check("Z_busy", bc, 2361);
        check("Z_writes", wr_cnt - w0, 1201);
        check("Z_word1159", mem[1159], 32'h0771_4A5A);
        check("Z_word1199", mem[1199], 32'h4A20_4A20);
        check("Z_cursor", {cursor_row, cursor_col}, {5'd29, 7'd0});

        // Reset in the middle of a scroll
        @(negedge clk);
        ch_valid = 1'b1; ch_data = 8'h0A; ch_attr = 8'h11;
        @(negedge clk);
        ch_valid = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        $display("reset mid-scroll: en %0b we %b addr %0d wdata %08h ready %0b busy %0b cursor (%0d,%0d)",
                 fb_en, fb_we, fb_addr, fb_wdata, ch_ready, busy, cursor_row, cursor_col);
        check("mrst_fb_en", fb_en, 0);
        check("mrst_fb_we", fb_we, 0);
        check("mrst_fb_addr", fb_addr, 0);
        check("mrst_fb_wdata", fb_wdata, 0);
        check("mrst_ready", ch_ready, 1);
        check("mrst_busy", busy, 0);
        check("mrst_cursor", {cursor_row, cursor_col}, 0);
        w0 = wr_cnt;
        r0 = rd_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("mrst_no_writes", wr_cnt - w0, 0);
        check("mrst_no_reads", rd_cnt - r0, 0);
        check("mrst_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
